// File: rtl/sata_rsp_pkg.sv
// Shared types and constants for the SATA command responder.
// Optional write-data checking in the responder is enabled by SATA_RSP_WR_CHECK_EN.
package sata_rsp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_WAIT,
      S_XFER,
      S_DONE,
      S_ERROR
   } state_e;

   localparam int XFER_DMA_RD = 3;
   localparam int XFER_DMA_WR = 4;

   localparam logic [7:0] ATA_RD_DMA_EXT = 8'h25;
   localparam logic [7:0] ATA_WR_DMA_EXT = 8'h35;

   typedef struct packed {
      logic [6:0]  xreq;
      logic [7:0]  opcode;
      logic [47:0] lba;
      logic [16:0] cnt;
      logic        is_dma;
   } cmd_t;

   // True when a latched command is well formed and fits inside the drive.
   function automatic logic cmd_ok(input cmd_t c, input logic [47:0] max_lba);
      logic [6:0] rd_hot;
      logic [6:0] wr_hot;
      logic       dir_ok;
      logic       op_ok;
      logic       cnt_ok;
      logic       range_ok;
      rd_hot              = '0;
      wr_hot              = '0;
      rd_hot[XFER_DMA_RD] = 1'b1;
      wr_hot[XFER_DMA_WR] = 1'b1;
      dir_ok   = (c.xreq == rd_hot) || (c.xreq == wr_hot);
      op_ok    = (c.xreq == wr_hot) ? (c.opcode == ATA_WR_DMA_EXT)
                                    : (c.opcode == ATA_RD_DMA_EXT);
      cnt_ok   = (c.cnt != 17'd0) && (c.cnt <= 17'h1_0000);
      range_ok = ({1'b0, c.lba} + 49'(c.cnt)) <= ({1'b0, max_lba} + 49'd1);
      return dir_ok && op_ok && cnt_ok && range_ok && c.is_dma;
   endfunction

endpackage

// File: rtl/sata_rsp_pattern.sv
// Deterministic sector data word: {lba[15:0], word index}; shared by the read
// source and the write checker so both sides agree on the same pattern.
module sata_rsp_pattern #(
   parameter int IDX_W = 7
) (
   input  logic [15:0]      lba_lo,
   input  logic [IDX_W-1:0] word_idx,
   output logic [31:0]      word
);

   assign word = {lba_lo, 16'(word_idx)};

endmodule

// File: rtl/sata_cmd_responder.sv
// Device-side SATA DMA command responder: decodes a command, waits, then streams sector data.
// Define SATA_RSP_WR_CHECK_EN to compare incoming write data against the read pattern.
module sata_cmd_responder
   import sata_rsp_pkg::*;
#(
   parameter int          WORDS_PER_SECTOR = 128,
   parameter int          CMD_LATENCY      = 16,
   parameter logic [47:0] MAX_LBA          = 48'h0000_0FFF_FFFF
) (
   input  logic        SystemClk,
   input  logic        nRESET,
   input  logic [6:0]  XferReq,
   input  logic [7:0]  CmdCommand,
   input  logic [47:0] CmdLBA,
   input  logic [16:0] CmdSectorCnt,
   input  logic        CmdIsDma,
   input  logic        err_clear,
   output logic [47:0] MAXLBA,
   output logic        DevReady,
   output logic        sata_error,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   input  logic [31:0] wr_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [16:0] sectors_done
);

   localparam int IDX_W = (WORDS_PER_SECTOR > 1) ? $clog2(WORDS_PER_SECTOR) : 1;
   localparam int LAT_W = (CMD_LATENCY > 1) ? $clog2(CMD_LATENCY) : 1;

   state_e            state_q, state_d;
   cmd_t              cmd_q, cmd_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [15:0]       lba_q, lba_d;
   logic [16:0]       done_q, done_d;
`ifdef SATA_RSP_WR_CHECK_EN
   logic              wr_err_q, wr_err_d;
`else
   logic              unused_wr_data;
   assign unused_wr_data = ^wr_data;
`endif

   logic [31:0] pattern;
   logic        is_wr;
   logic        hs;
   logic        last_word;
   logic        last_sector;

   sata_rsp_pattern #(.IDX_W(IDX_W)) u_pattern (
      .lba_lo   (lba_q),
      .word_idx (idx_q),
      .word     (pattern)
   );

   assign is_wr       = cmd_q.xreq[XFER_DMA_WR];
   assign hs          = is_wr ? wr_valid : rd_ready;
   assign last_word   = (idx_q == IDX_W'(WORDS_PER_SECTOR - 1));
   assign last_sector = ((done_q + 17'd1) == cmd_q.cnt);

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop regardless of block order.
   always_ff @(posedge SystemClk or negedge nRESET) begin
      if (!nRESET) begin
         state_q  <= S_IDLE;
         cmd_q    <= '0;
         lat_q    <= '0;
         idx_q    <= '0;
         lba_q    <= '0;
         done_q   <= '0;
`ifdef SATA_RSP_WR_CHECK_EN
         wr_err_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         lat_q    <= lat_d;
         idx_q    <= idx_d;
         lba_q    <= lba_d;
         done_q   <= done_d;
`ifdef SATA_RSP_WR_CHECK_EN
         wr_err_q <= wr_err_d;
`endif
      end
   end

   // NOTE: every _d gets a hold default before the case, so no path leaves a
   // variable unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      lat_d    = lat_q;
      idx_d    = idx_q;
      lba_d    = lba_q;
      done_d   = done_q;
`ifdef SATA_RSP_WR_CHECK_EN
      wr_err_d = wr_err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (XferReq != 7'd0) begin
               cmd_d   = cmd_t'{xreq: XferReq, opcode: CmdCommand, lba: CmdLBA,
                                cnt: CmdSectorCnt, is_dma: CmdIsDma};
               done_d  = '0;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            lat_d    = '0;
            idx_d    = '0;
            lba_d    = cmd_q.lba[15:0];
`ifdef SATA_RSP_WR_CHECK_EN
            wr_err_d = 1'b0;
`endif
            state_d  = cmd_ok(cmd_q, MAX_LBA) ? S_WAIT : S_ERROR;
         end
         S_WAIT: begin
            if (lat_q == LAT_W'(CMD_LATENCY - 1)) state_d = S_XFER;
            else                                  lat_d   = lat_q + LAT_W'(1);
         end
         S_XFER: begin
            if (hs) begin
`ifdef SATA_RSP_WR_CHECK_EN
               if (is_wr && (wr_data != pattern)) wr_err_d = 1'b1;
`endif
               if (last_word) begin
                  idx_d  = '0;
                  lba_d  = lba_q + 16'd1;
                  done_d = done_q + 17'd1;
                  if (last_sector) state_d = S_DONE;
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
               end
            end
         end
         S_DONE: begin
`ifdef SATA_RSP_WR_CHECK_EN
            state_d = wr_err_q ? S_ERROR : S_IDLE;
`else
            state_d = S_IDLE;
`endif
         end
         S_ERROR: begin
            if (err_clear) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      DevReady     = (state_q == S_IDLE) || (state_q == S_ERROR);
      sata_error   = (state_q == S_ERROR);
      rd_valid     = (state_q == S_XFER) && !is_wr;
      wr_ready     = (state_q == S_XFER) && is_wr;
      rd_data      = rd_valid ? pattern : 32'd0;
      sectors_done = done_q;
   end

   assign MAXLBA = MAX_LBA;

endmodule

// File: tb/tb_sata_cmd_responder.sv
// Directed self-checking bench for sata_cmd_responder; expectations adapt to
// whether SATA_RSP_WR_CHECK_EN is defined for the build.
module tb_sata_cmd_responder;

   localparam int          WPS  = 128;
   localparam int          LAT  = 16;
   localparam logic [47:0] MAXL = 48'h0000_0FFF_FFFF;
`ifdef SATA_RSP_WR_CHECK_EN
   localparam logic WR_CHK = 1'b1;
`else
   localparam logic WR_CHK = 1'b0;
`endif

   logic        SystemClk;
   logic        nRESET;
   logic [6:0]  XferReq;
   logic [7:0]  CmdCommand;
   logic [47:0] CmdLBA;
   logic [16:0] CmdSectorCnt;
   logic        CmdIsDma;
   logic        err_clear;
   logic [47:0] MAXLBA;
   logic        DevReady;
   logic        sata_error;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [31:0] wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [16:0] sectors_done;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] first_w, last_w;

   sata_cmd_responder #(
      .WORDS_PER_SECTOR (WPS),
      .CMD_LATENCY      (LAT),
      .MAX_LBA          (MAXL)
   ) dut (
      .SystemClk    (SystemClk),
      .nRESET       (nRESET),
      .XferReq      (XferReq),
      .CmdCommand   (CmdCommand),
      .CmdLBA       (CmdLBA),
      .CmdSectorCnt (CmdSectorCnt),
      .CmdIsDma     (CmdIsDma),
      .err_clear    (err_clear),
      .MAXLBA       (MAXLBA),
      .DevReady     (DevReady),
      .sata_error   (sata_error),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .wr_data      (wr_data),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .sectors_done (sectors_done)
   );

   initial SystemClk = 1'b0;
   always #5 SystemClk = ~SystemClk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected stream word w of a transfer that starts at lba.
   function automatic logic [31:0] pat(input logic [47:0] lba, input int w);
      return {lba[15:0] + 16'(w / WPS), 16'(w % WPS)};
   endfunction

   // Called at a negedge; returns at the negedge of cycle N+1.
   task automatic issue(input logic [6:0] xr, input logic [7:0] op, input logic [47:0] lba,
                        input logic [16:0] cnt, input logic dma);
      XferReq      = xr;
      CmdCommand   = op;
      CmdLBA       = lba;
      CmdSectorCnt = cnt;
      CmdIsDma     = dma;
      @(negedge SystemClk);
      XferReq = '0;
      check("busy_at_n1", DevReady, 1'b0);
   endtask

   task automatic clear_error(input string tag);
      err_clear = 1'b1;
      @(negedge SystemClk);
      err_clear = 1'b0;
      check({tag, "_cleared_err"}, sata_error, 1'b0);
      check({tag, "_cleared_rdy"}, DevReady, 1'b1);
   endtask

   task automatic expect_reject(input string tag);
      @(negedge SystemClk);
      check({tag, "_devready"}, DevReady, 1'b1);
      check({tag, "_error"}, sata_error, 1'b1);
      check({tag, "_no_stream"}, {rd_valid, wr_ready}, 2'b00);
      clear_error(tag);
   endtask

   task automatic run_read(input logic [47:0] lba, input logic [16:0] cnt, input int stall_at,
                           input int stop_at);
      int   total;
      int   limit;
      int   words  = 0;
      int   bad    = 0;
      int   early  = 0;
      int   budget = 5000;
      int   stall_bad;
      bit   stalled = 1'b0;
      logic [31:0] held;
      total    = int'(cnt) * WPS;
      limit    = (stop_at >= 0) ? stop_at : total;
      rd_ready = 1'b1;
      for (int i = 0; i <= LAT; i++) begin
         if (rd_valid !== 1'b0) early++;
         @(negedge SystemClk);
      end
      check("rd_quiet_in_wait", early, 0);
      check("rd_first_valid", rd_valid, 1'b1);
      while (words < limit && budget > 0) begin
         if (rd_valid) begin
            if (words == stall_at && !stalled) begin
               held      = rd_data;
               rd_ready  = 1'b0;
               stall_bad = 0;
               for (int s = 0; s < 20; s++) begin
                  if (s == 10) begin
                     XferReq    = 7'b0010000;
                     CmdCommand = 8'h35;
                  end
                  if (s == 11) XferReq = '0;
                  @(negedge SystemClk);
                  if (rd_data !== held || rd_valid !== 1'b1) stall_bad++;
               end
               check("rd_stall_stable", stall_bad, 0);
               rd_ready = 1'b1;
               stalled  = 1'b1;
            end
            if (words == 0) first_w = rd_data;
            last_w = rd_data;
            if (rd_data !== pat(lba, words)) bad++;
            words++;
         end
         @(negedge SystemClk);
         budget--;
      end
      check("rd_word_count", words, limit);
      check("rd_pattern_errs", bad, 0);
      if (limit < total) return;
      check("rd_done_busy", DevReady, 1'b0);
      check("rd_done_novalid", rd_valid, 1'b0);
      @(negedge SystemClk);
      check("rd_cmpl_ready", DevReady, 1'b1);
      check("rd_cmpl_error", sata_error, 1'b0);
      check("rd_cmpl_sectors", sectors_done, cnt);
   endtask

   task automatic run_write(input logic [47:0] lba, input logic [16:0] cnt, input int corrupt_at,
                            input logic exp_err);
      int   total;
      int   words  = 0;
      int   budget = 5000;
      logic phase  = 1'b0;
      logic hs;
      total = int'(cnt) * WPS;
      while (words < total && budget > 0) begin
         wr_valid = phase;
         wr_data  = pat(lba, words) ^ ((words == corrupt_at) ? 32'h0000_0100 : 32'h0);
         hs       = wr_valid && wr_ready;
         @(negedge SystemClk);
         if (hs) words++;
         phase = ~phase;
         budget--;
      end
      wr_valid = 1'b0;
      check("wr_word_count", words, total);
      check("wr_done_busy", DevReady, 1'b0);
      check("wr_done_noready", wr_ready, 1'b0);
      @(negedge SystemClk);
      check("wr_cmpl_ready", DevReady, 1'b1);
      check("wr_cmpl_error", sata_error, exp_err);
      check("wr_cmpl_sectors", sectors_done, cnt);
   endtask

   initial begin
      nRESET       = 1'b0;
      XferReq      = '0;
      CmdCommand   = '0;
      CmdLBA       = '0;
      CmdSectorCnt = '0;
      CmdIsDma     = 1'b0;
      err_clear    = 1'b0;
      rd_ready     = 1'b0;
      wr_data      = '0;
      wr_valid     = 1'b0;
      repeat (3) @(negedge SystemClk);
      nRESET = 1'b1;
      @(negedge SystemClk);
      check("rst_devready", DevReady, 1'b1);
      check("rst_error", sata_error, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_wr_ready", wr_ready, 1'b0);
      check("rst_rd_data", rd_data, 32'h0);
      check("rst_sectors", sectors_done, 17'h0);
      check("maxlba", MAXLBA, 48'h0000_0FFF_FFFF);

      // Two-sector read from LBA 0x10.
      issue(7'b0001000, 8'h25, 48'h10, 17'd2, 1'b1);
      run_read(48'h10, 17'd2, -1, -1);
      check("rd1_first_word", first_w, 32'h0010_0000);
      check("rd1_last_word", last_w, 32'h0011_007F);

      // Clean single-sector write with 50% valid duty.
      issue(7'b0010000, 8'h35, 48'h20, 17'd1, 1'b1);
      run_write(48'h20, 17'd1, -1, 1'b0);

      // Write with word 5 corrupted.
      issue(7'b0010000, 8'h35, 48'h30, 17'd1, 1'b1);
      run_write(48'h30, 17'd1, 5, WR_CHK);
      if (WR_CHK) begin
         repeat (4) @(negedge SystemClk);
         check("wrerr_sticky", sata_error, 1'b1);
         XferReq    = 7'b0001000;
         CmdCommand = 8'h25;
         @(negedge SystemClk);
         XferReq = '0;
         check("wrerr_ignore_req_rdy", DevReady, 1'b1);
         @(negedge SystemClk);
         check("wrerr_ignore_req_err", sata_error, 1'b1);
         clear_error("wrerr");
      end

      // Rejected commands.
      issue(7'b0010000, 8'h25, 48'h40, 17'd1, 1'b1);
      expect_reject("rej_wr_opcode");
      issue(7'b0001000, 8'h25, MAXL, 17'd2, 1'b1);
      expect_reject("rej_lba_range");
      issue(7'b0001000, 8'h25, 48'h40, 17'd0, 1'b1);
      expect_reject("rej_count_zero");
      issue(7'b0011000, 8'h25, 48'h40, 17'd1, 1'b1);
      expect_reject("rej_two_hot");
      issue(7'b0001000, 8'h25, 48'h40, 17'd1, 1'b0);
      expect_reject("rej_not_dma");
      issue(7'b0001000, 8'h25, 48'h40, 17'h1_0001, 1'b1);
      expect_reject("rej_count_big");

      // Last sector of the drive is legal.
      issue(7'b0001000, 8'h25, MAXL, 17'd1, 1'b1);
      run_read(MAXL, 17'd1, -1, -1);
      check("edge_first_word", first_w, 32'hFFFF_0000);

      // Consumer stall mid-sector with a stray request during XFER.
      issue(7'b0001000, 8'h25, 48'h40, 17'd1, 1'b1);
      run_read(48'h40, 17'd1, 50, -1);
      @(negedge SystemClk);
      check("stray_req_ignored", DevReady, 1'b1);

      // Asynchronous reset in the middle of the second sector.
      issue(7'b0001000, 8'h25, 48'h50, 17'd2, 1'b1);
      run_read(48'h50, 17'd2, -1, 130);
      check("abort_pre_sectors", sectors_done, 17'd1);
      #2 nRESET = 1'b0;
      #1;
      check("abort_devready", DevReady, 1'b1);
      check("abort_error", sata_error, 1'b0);
      check("abort_rd_valid", rd_valid, 1'b0);
      check("abort_wr_ready", wr_ready, 1'b0);
      check("abort_rd_data", rd_data, 32'h0);
      check("abort_sectors", sectors_done, 17'h0);
      @(negedge SystemClk);
      nRESET = 1'b1;
      @(negedge SystemClk);
      issue(7'b0001000, 8'h25, 48'h60, 17'd1, 1'b1);
      run_read(48'h60, 17'd1, -1, -1);
      check("post_rst_first_word", first_w, 32'h0060_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
